// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding,
// datapath constants and the fetch address range check.
package if_pkg;

  // FSM state encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // A fetch is legal only when the full word index lies inside the memory.
  // The whole index is compared, not just the bits that address the memory,
  // so a PC that wraps or runs past the end is caught.
  function automatic logic word_in_range(input logic [29:0] word_idx,
                                         input int unsigned mem_words);
    return {2'b00, word_idx} < mem_words;
  endfunction

endpackage

// File: rtl/if_out_stage.sv
// Valid/ready output register with flush. A push loads new data and sets
// valid; otherwise an accepted entry drains. Flush drops valid and
// overrides everything else. The producer must only push when the slot
// is free or being accepted in the same cycle.
module if_out_stage #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              flush,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  // Valid flag: flush beats push, push beats drain.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Payload register: only changes on a push, so it is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (push && !flush) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequences the PC, reads the combinational
// instruction memory and hands instructions to decode through a registered
// valid/ready slot. Handles redirects, halt/resume and a sticky fetch fault.
module fetch_controller
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               halt_req,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        fault_nxt;
  logic        push, flush, load;

  assign imem_addr = pc;
  // The slot can take a new instruction when empty or being drained now.
  assign load = !if_valid || if_ready;

  // Next-state, next-PC and output-stage control.
  // NOTE: every always_comb output gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault;
    push      = 1'b0;
    flush     = 1'b0;
    if (state == ST_BOOT) begin
      state_nxt = halt_req ? ST_HALT : ST_RUN;
    end else if (redirect_valid) begin
      // Redirect wins over stall, halt and fault; no fetch this cycle.
      flush  = 1'b1;
      pc_nxt = redirect_target;
      if (redirect_target[1:0] != 2'b00) begin
        state_nxt = ST_FAULT;
        fault_nxt = 1'b1;
      end else if (state == ST_FAULT) begin
        state_nxt = ST_RUN;
        fault_nxt = 1'b0;
      end
    end else if (state == ST_RUN) begin
      if (load) begin
        if (word_in_range(pc[31:2], MEM_WORDS)) begin
          push   = 1'b1;
          pc_nxt = pc + PC_STEP;
          if (halt_req) state_nxt = ST_HALT;
        end else begin
          // PC stays on the offending address for debug.
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end
      end else if (halt_req) begin
        state_nxt = ST_HALT;
      end
    end else if (state == ST_HALT) begin
      if (!halt_req) state_nxt = ST_RUN;
    end
  end

  // FSM, PC and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      fault <= fault_nxt;
    end
  end

  // Count decode acceptances; flushes do not undo an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (if_valid && if_ready) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  logic [31+INSTR_W:0] out_data;

  if_out_stage #(
    .DATA_W (32 + INSTR_W)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .flush    (flush),
    .ready    (if_ready),
    .data_in  ({pc, imem_data}),
    .valid    (if_valid),
    .data_out (out_data)
  );

  assign if_pc    = out_data[31+INSTR_W:INSTR_W];
  assign if_instr = out_data[INSTR_W-1:0];

endmodule
